// File: rtl/ascii_ps2_tx.sv
// PS/2 keyboard emulator: turns one ASCII character into a set-2 make code,
// a break prefix and the make code again, driven as three 11-bit PS/2 frames.
module ascii_ps2_tx #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_code,
    input  logic       start,
    output logic       ps2c,
    output logic       ps2d,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CELL    = 2 * CLK_DIV;
    localparam int CNT_MAX = (CELL > GAP_CYCLES) ? CELL : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CELL_LAST = CW'(CELL - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic [1:0]    frame_idx, frame_n;
    logic [7:0]    code, code_n;
    logic          err_n;
    logic [8:0]    lookup;
    logic [7:0]    cur_byte;
    logic [10:0]   frame_bits;

    // Returns {mapped, make_code}; lowercase letters fold onto uppercase.
    function automatic logic [8:0] make_code(input logic [7:0] a);
        logic [7:0] u;
        logic [8:0] r;
        u = (a >= 8'h61 && a <= 8'h7A) ? a - 8'h20 : a;
        r = {1'b1, 8'h00};
        case (u)
            8'h30: r[7:0] = 8'h45;  8'h31: r[7:0] = 8'h16;  8'h32: r[7:0] = 8'h1E;
            8'h33: r[7:0] = 8'h26;  8'h34: r[7:0] = 8'h25;  8'h35: r[7:0] = 8'h2E;
            8'h36: r[7:0] = 8'h36;  8'h37: r[7:0] = 8'h3D;  8'h38: r[7:0] = 8'h3E;
            8'h39: r[7:0] = 8'h46;
            8'h41: r[7:0] = 8'h1C;  8'h42: r[7:0] = 8'h32;  8'h43: r[7:0] = 8'h21;
            8'h44: r[7:0] = 8'h23;  8'h45: r[7:0] = 8'h24;  8'h46: r[7:0] = 8'h2B;
            8'h47: r[7:0] = 8'h34;  8'h48: r[7:0] = 8'h33;  8'h49: r[7:0] = 8'h43;
            8'h4A: r[7:0] = 8'h3B;  8'h4B: r[7:0] = 8'h42;  8'h4C: r[7:0] = 8'h4B;
            8'h4D: r[7:0] = 8'h3A;  8'h4E: r[7:0] = 8'h31;  8'h4F: r[7:0] = 8'h44;
            8'h50: r[7:0] = 8'h4D;  8'h51: r[7:0] = 8'h15;  8'h52: r[7:0] = 8'h2D;
            8'h53: r[7:0] = 8'h1B;  8'h54: r[7:0] = 8'h2C;  8'h55: r[7:0] = 8'h3C;
            8'h56: r[7:0] = 8'h2A;  8'h57: r[7:0] = 8'h1D;  8'h58: r[7:0] = 8'h22;
            8'h59: r[7:0] = 8'h35;  8'h5A: r[7:0] = 8'h1A;
            8'h60: r[7:0] = 8'h0E;  8'h2D: r[7:0] = 8'h4E;  8'h3D: r[7:0] = 8'h55;
            8'h5B: r[7:0] = 8'h54;  8'h5D: r[7:0] = 8'h5B;  8'h5C: r[7:0] = 8'h5D;
            8'h3B: r[7:0] = 8'h4C;  8'h27: r[7:0] = 8'h52;  8'h2C: r[7:0] = 8'h41;
            8'h2E: r[7:0] = 8'h49;  8'h2F: r[7:0] = 8'h4A;  8'h20: r[7:0] = 8'h29;
            8'h0D: r[7:0] = 8'h5A;  8'h08: r[7:0] = 8'h66;
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign lookup     = make_code(ascii_code);
    assign cur_byte   = (frame_idx == 2'd1) ? 8'hF0 : code;
    // Stop, odd parity, data LSB first, start -- index 0 goes out first.
    assign frame_bits = {1'b1, ~^cur_byte, cur_byte, 1'b0};

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_idx <= '0;
            code      <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            frame_idx <= frame_n;
            code      <= code_n;
            err       <= err_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        frame_n = frame_idx;
        code_n  = code;
        err_n   = 1'b0;
        ps2c    = 1'b1;
        ps2d    = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;

        case (state)
            IDLE, DONE: begin
                done    = (state == DONE);
                state_n = IDLE;
                if (start) begin
                    if (lookup[8]) begin
                        state_n = SEND;
                        code_n  = lookup[7:0];
                        cnt_n   = '0;
                        bit_n   = '0;
                        frame_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SEND: begin
                busy = 1'b1;
                ps2c = (cnt < HALF);
                ps2d = frame_bits[bit_idx];
                if (cnt == CELL_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd10) begin
                        bit_n = '0;
                        if (frame_idx == 2'd2) begin
                            state_n = DONE;
                        end else begin
                            frame_n = frame_idx + 2'd1;
                            state_n = (GAP_CYCLES > 0) ? GAP : SEND;
                        end
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            GAP: begin
                busy = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// Bench for ascii_ps2_tx: per-cycle comparison of {ps2c,ps2d,busy,done,err}
// against a waveform generated from the PS/2 framing rules.
module tb_ascii_ps2_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ascii_code;
    logic       ps2c, ps2d, busy, done, err;

    int errors = 0;
    int checks = 0;

    logic [7:0] ps2_map [int];
    int         mapped_keys [$];
    logic [4:0] exp_q [$];

    ascii_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .ascii_code (ascii_code),
        .start      (start),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic build_map();
        logic [7:0]  digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                           8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0]  letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                           8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                           8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                           8'h35, 8'h1A};
        logic [15:0] punct [14] = '{16'h600E, 16'h2D4E, 16'h3D55, 16'h5B54, 16'h5D5B,
                                    16'h5C5D, 16'h3B4C, 16'h2752, 16'h2C41, 16'h2E49,
                                    16'h2F4A, 16'h2029, 16'h0D5A, 16'h0866};
        for (int i = 0; i < 10; i++) ps2_map[8'h30 + i] = digit_codes[i];
        for (int i = 0; i < 26; i++) begin
            ps2_map[8'h41 + i] = letter_codes[i];
            ps2_map[8'h61 + i] = letter_codes[i];
        end
        for (int i = 0; i < 14; i++) ps2_map[int'(punct[i][15:8])] = punct[i][7:0];
        foreach (ps2_map[k]) mapped_keys.push_back(k);
    endtask

    // Expected per-cycle outputs from the first busy cycle through the done cycle.
    function automatic void gen_wave(input logic [7:0] mk);
        logic [7:0] b;
        logic       bits [11];
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            b = (f == 1) ? 8'hF0 : mk;
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
            bits[9]  = ($countones(b) % 2 == 0);
            bits[10] = 1'b1;
            for (int i = 0; i < 11; i++) begin
                repeat (CLK_DIV) exp_q.push_back({1'b1, bits[i], 3'b100});
                repeat (CLK_DIV) exp_q.push_back({1'b0, bits[i], 3'b100});
            end
            if (f < 2) repeat (GAP) exp_q.push_back(5'b11100);
        end
        exp_q.push_back(5'b11010);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] expv);
        logic [4:0] obs;
        obs = {ps2c, ps2d, busy, done, err};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed c,d,busy,done,err=%b required %b at %0t",
                   tag, obs, expv, $time);
        end
    endtask

    task automatic issue(input logic [7:0] ch);
        ascii_code = ch;
        start      = 1'b1;
    endtask

    // Caller has raised start in the current cycle. mode 0: drop start after
    // one cycle; mode 1: random start pulses with '0' while busy; mode 2: leave start.
    task automatic run_char(input string tag, input logic [7:0] ch,
                            input int mode, input int abort_at);
        int n;
        gen_wave(ps2_map[int'(ch)]);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            expect_out($sformatf("%s[%0d]", tag, k), exp_q[k]);
            if (mode == 0 && k == 0) start = 1'b0;
            if (mode == 1) begin
                if (k < n - 3) begin
                    start      = 1'($urandom_range(0, 1));
                    ascii_code = 8'h30;
                end else begin
                    start = 1'b0;
                end
            end
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                expect_out({tag, "_abort"}, 5'b11000);
                return;
            end
        end
    endtask

    task automatic run_err(input string tag, input logic [7:0] ch);
        issue(ch);
        tick();
        start = 1'b0;
        expect_out({tag, "_err"}, 5'b11001);
        tick();
        expect_out({tag, "_after"}, 5'b11000);
    endtask

    initial begin
        logic [7:0] v;
        build_map();
        reset      = 1'b1;
        start      = 1'b0;
        ascii_code = 8'h00;
        repeat (3) tick();
        expect_out("reset_hold", 5'b11000);
        reset = 1'b0;
        tick();
        expect_out("reset_idle", 5'b11000);

        issue(8'h41);
        run_char("A", 8'h41, 0, -1);
        tick();
        expect_out("A_idle", 5'b11000);

        issue(8'h61);
        run_char("a", 8'h61, 0, -1);
        tick();
        expect_out("a_idle", 5'b11000);

        run_err("tilde", 8'h7E);

        issue(8'h5A);
        run_char("Z_ignore", 8'h5A, 1, -1);
        tick();
        expect_out("Z_single_done", 5'b11000);

        // Frame 2 starts at 11 cells + gap; land mid-way through its bit 5.
        issue(8'h30);
        run_char("abort", 8'h30, 0, 11 * 2 * CLK_DIV + GAP + 5 * 2 * CLK_DIV + 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("abort_idle", 5'b11000);
        end
        issue(8'h08);
        run_char("bs", 8'h08, 0, -1);
        tick();
        expect_out("bs_idle", 5'b11000);

        reset = 1'b1;
        issue(8'h41);
        tick();
        reset = 1'b0;
        start = 1'b0;
        expect_out("reset_vs_start", 5'b11000);
        tick();
        expect_out("reset_vs_start_idle", 5'b11000);

        issue(8'h4B);
        run_char("K1", 8'h4B, 2, -1);
        run_char("K2", 8'h4B, 0, -1);
        tick();
        expect_out("K_idle", 5'b11000);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1)
                v = 8'(mapped_keys[$urandom_range(0, mapped_keys.size() - 1)]);
            else
                v = 8'($urandom_range(0, 255));
            if (ps2_map.exists(int'(v))) begin
                issue(v);
                run_char($sformatf("rnd%0d_%h", r, v), v, 0, -1);
                tick();
                expect_out($sformatf("rnd%0d_idle", r), 5'b11000);
            end else begin
                run_err($sformatf("rnd%0d_%h", r, v), v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
